// File: rtl/tone_period_meter_pkg.sv
// +----------------------------------------------------------------------------+
// | tone_period_meter_pkg                                                      |
// | Shared state encoding, default sizing and the note-period table.           |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package tone_period_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_LOCKED = 2'd2
  } meter_state_t;

  localparam int c_cnt_w        = 24;
  localparam int c_timeout      = 2000000;
  localparam int c_min_period   = 4;
  localparam int c_sync_stages  = 2;

  // I_CLK cycles per note period at a 50 MHz I_CLK, C4 through C5.
  localparam int unsigned c_note_c4 = 191110;
  localparam int unsigned c_note_d4 = 170265;
  localparam int unsigned c_note_e4 = 151685;
  localparam int unsigned c_note_f4 = 143172;
  localparam int unsigned c_note_g4 = 127551;
  localparam int unsigned c_note_a4 = 113636;
  localparam int unsigned c_note_b4 = 101239;
  localparam int unsigned c_note_c5 = 95557;

  function automatic int unsigned note_cycles(input logic [2:0] idx);
    int unsigned cycles;
    case (idx)
      3'd0:    cycles = c_note_c4;
      3'd1:    cycles = c_note_d4;
      3'd2:    cycles = c_note_e4;
      3'd3:    cycles = c_note_f4;
      3'd4:    cycles = c_note_g4;
      3'd5:    cycles = c_note_a4;
      3'd6:    cycles = c_note_b4;
      default: cycles = c_note_c5;
    endcase
    return cycles;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tone_period_meter_sync_edge_detect.sv
// +----------------------------------------------------------------------------+
// | sync_edge_detect                                                           |
// | Multi-stage synchroniser with priming guard and registered edge strobes.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic I_CLK,
  input  logic Rst,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  localparam int c_prime_w = $clog2(SYNC_STAGES + 2);
  localparam logic [c_prime_w-1:0] c_prime_done = c_prime_w'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [c_prime_w-1:0]   r_prime_cnt;
  logic                   w_level;
  logic                   w_primed;

  assign w_level  = r_sync[SYNC_STAGES-1];
  // Until the chain and r_prev hold real samples, a stale-vs-new compare is meaningless.
  assign w_primed = (r_prime_cnt == c_prime_done);

  always_ff @(posedge I_CLK) begin
    if (Rst) begin
      r_sync      <= '0;
      r_prev      <= 1'b0;
      r_prime_cnt <= '0;
      o_rise      <= 1'b0;
      o_fall      <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
      r_prev <= w_level;
      if (!w_primed) begin
        r_prime_cnt <= r_prime_cnt + c_prime_w'(1);
      end
      o_rise <= w_primed & w_level & ~r_prev;
      o_fall <= w_primed & ~w_level & r_prev;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tone_period_meter.sv
// +----------------------------------------------------------------------------+
// | tone_period_meter                                                          |
// | Measures period and high time of a square wave in I_CLK cycles.            |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tone_period_meter
  import tone_period_meter_pkg::*;
#(
  parameter int CNT_W       = c_cnt_w,
  parameter int TIMEOUT     = c_timeout,
  parameter int MIN_PERIOD  = c_min_period,
  parameter int SYNC_STAGES = c_sync_stages
) (
  input  logic             I_CLK,
  input  logic             Rst,
  input  logic             Sig_In,
  output logic [CNT_W-1:0] Period_Out,
  output logic [CNT_W-1:0] High_Out,
  output logic             Valid,
  output logic             Locked,
  output logic             Timeout
);

  localparam logic [CNT_W-1:0] c_timeout_v = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] c_to_last   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_min_v     = CNT_W'(MIN_PERIOD);

  meter_state_t     r_state;
  meter_state_t     w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_hi_cap;
  logic             r_hi_seen;
  logic             w_rise;
  logic             w_fall;
  logic             w_accept;
  logic             w_publish;
  logic             w_timeout;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_detect (
    .I_CLK  (I_CLK),
    .Rst    (Rst),
    .i_sig  (Sig_In),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // The first rise only sets the reference, so IDLE accepts any rise.
  assign w_accept = w_rise & ((r_state == ST_IDLE) | (r_cnt >= c_min_v));

  always_comb begin
    w_state_nxt = r_state;
    w_publish   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_ARMED, ST_LOCKED: begin
        if (w_accept) begin
          w_publish   = 1'b1;
          w_state_nxt = ST_LOCKED;
        end else if (r_cnt == c_to_last) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_accept) begin
      w_cnt_nxt = CNT_W'(1);
    end else if (r_cnt != c_timeout_v) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge I_CLK) begin
    if (Rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_hi_cap   <= '0;
      r_hi_seen  <= 1'b0;
      Period_Out <= '0;
      High_Out   <= '0;
      Valid      <= 1'b0;
      Locked     <= 1'b0;
      Timeout    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      Valid   <= w_publish;
      Timeout <= w_timeout;

      if (w_accept) begin
        r_hi_seen <= 1'b0;
      end else if (w_fall && !r_hi_seen) begin
        r_hi_seen <= 1'b1;
        r_hi_cap  <= r_cnt;
      end

      if (w_publish) begin
        Period_Out <= r_cnt;
        High_Out   <= r_hi_seen ? r_hi_cap : '0;
        Locked     <= 1'b1;
      end else if (w_timeout) begin
        Period_Out <= '0;
        High_Out   <= '0;
        Locked     <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/tone_period_meter.md
Name: tone_period_meter

Overview:
- Measures an incoming square wave, such as a tone produced by the team's clock divider or an externally supplied note clock.
- Reports the period and high time in I_CLK cycles, which lets the player self-check generated notes against the note table.
- Synchronises the async input, detects edges, rejects glitches, declares loss-of-tone on timeout, and publishes one measurement per accepted rising edge.

Parameters:
CNT_W, 24, width of all cycle counters and measurement outputs
TIMEOUT, 2000000, I_CLK cycles without an accepted rise before loss-of-tone; must satisfy 4 <= TIMEOUT < 2^CNT_W
MIN_PERIOD, 4, rises arriving fewer than this many cycles after the last accepted rise are glitches and are ignored
SYNC_STAGES, 2, synchroniser depth; must be >= 2

Ports:
I_CLK  input  1  clock
Rst  input  1  synchronous, active-high reset
Sig_In  input  1  asynchronous square wave to measure
Period_Out  output  CNT_W  last measured period in I_CLK cycles
High_Out  output  CNT_W  high time of the last measured period, in I_CLK cycles
Valid  output  1  one-cycle pulse when Period_Out/High_Out update
Locked  output  1  high while at least one valid period has been measured and no timeout since
Timeout  output  1  one-cycle pulse on loss-of-tone

Behaviour:
- Reset (Rst=1 at posedge I_CLK): Period_Out=0, High_Out=0, Valid=0, Locked=0, Timeout=0, state=IDLE, counters=0, synchroniser cleared.
- Edge detection is suppressed until the synchroniser is primed, SYNC_STAGES+1 cycles after Rst deassertion. A high Sig_In at reset release therefore never produces a false rise.
- Latency: Valid and outputs are registered. Valid is high in the cycle SYNC_STAGES+1 I_CLK edges after the edge that first samples the new Sig_In level.
- Counter cnt:
  - On an accepted rise, cnt<=1.
  - Otherwise cnt<=cnt+1, saturating at TIMEOUT.
  - Consequently cnt at the next accepted rise equals the rise-to-rise distance in cycles.
- Accepted rise: a detected rise with state=IDLE, or a detected rise with cnt>=MIN_PERIOD. Other rises are ignored entirely; cnt continues and hi_cap is unchanged.
- Fall: the first detected fall after an accepted rise latches hi_cap<=cnt. Further falls before the next accepted rise are ignored.
- States:
  - IDLE:
    - On an accepted rise, go to ARMED, clear hi_seen, cnt<=1.
  - ARMED: the first reference edge has been seen.
    - On an accepted rise: Period_Out<=cnt, High_Out<=(hi_seen ? hi_cap : 0), Valid<=1, Locked<=1, go to LOCKED.
  - LOCKED:
    - On an accepted rise, perform the same publish as ARMED and stay in LOCKED.
- Timeout (ARMED or LOCKED):
  - Fires when cnt==TIMEOUT-1 and no accepted rise occurs that cycle.
  - Timeout<=1 for one cycle, Locked<=0, Period_Out<=0, High_Out<=0, go to IDLE.
  - An accepted rise in the same cycle wins: it publishes and no timeout fires.
  - IDLE never times out.
- Constant input (Sig_In stuck high or low) leads to timeout and then IDLE, with no Valid.
- Rst mid-measurement aborts immediately; no partial result is published.

Decomposition:
- Shared package contains:
  - the state enum (IDLE, ARMED, LOCKED);
  - default CNT_W and TIMEOUT constants;
  - the I_CLK-cycles-per-note constants that the divider also uses, so benches and the player share one table.
- One sub-module: sync_edge_detect.
  - Contents: SYNC_STAGES flops, the priming counter, and registered rise/fall strobes.
  - Reset: Rst, synchronous.

Test Plan:
1. Sig_In toggles every 10 I_CLK cycles (period 20), same clock domain -> no Valid on first rise; Valid on second rise with Period_Out=20, High_Out=10, Locked=1; Valid on every later rise, exactly 20 cycles apart.
2. After lock, hold Sig_In low, TIMEOUT=1000 -> exactly one Timeout pulse 1000 cycles after the last Valid-producing detection; Locked=0, Period_Out=0, High_Out=0; the next two rises relock with correct values.
3. Period 20 with a 2-cycle glitch pulse 5 cycles after a rise, MIN_PERIOD=8 -> glitch rise ignored; Period_Out stays 20, High_Out=5 (first fall), no extra Valid.
4. Period 7, high 3 -> Period_Out=7, High_Out=3. Switch to period 40 mid-stream -> first Valid after the switch reports the boundary interval, the following Valid reports 40.
5. Assert Rst for 1 cycle while LOCKED with Sig_In high -> all outputs 0 next cycle; no false rise after release; the first Valid occurs at the second real rise after priming.
6. Accepted rise exactly at cnt==TIMEOUT-1 -> Valid with Period_Out=TIMEOUT-1, no Timeout pulse, Locked stays 1.
